ndiv_seq: RTL and testbench
===========================

NDIV_SEQ -- requirements
Module: ndiv_seq

Interface
REQ-001 SHALL provide parameter N_W, default 8, meaning integer divide-ratio width.
REQ-002 SHALL provide parameter FRAC_W, default 8, meaning fractional-word width (modulus 2^FRAC_W).
REQ-003 SHALL provide parameter M_LOG2, default 2, meaning log2 of the prescaler modulus M (4/5 prescaler).
REQ-004 SHALL provide port Fin, input, 1, meaning the single clock (divider input clock); all state on its rising edge.
REQ-005 SHALL provide port rst_n, input, 1, meaning asynchronous active-low reset.
REQ-006 SHALL provide port N_int, input, N_W, meaning integer divide ratio.
REQ-007 SHALL provide port frac, input, FRAC_W, meaning fractional part, unsigned, value frac/2^FRAC_W.
REQ-008 SHALL provide port LDi, input, 1, meaning reload strobe from the program counter; each Fin cycle with LDi=1 is one strobe.
REQ-009 SHALL provide port Po, output, N_W-M_LOG2, meaning program-counter value P (raw, uncorrected).
REQ-010 SHALL provide port So, output, M_LOG2, meaning swallow-counter value S.
REQ-011 SHALL provide port upd, output, 1, meaning one-cycle pulse marking new Po/So.

Function
REQ-012 SHALL sample N_int and frac only in a cycle with LDi=1; input changes between strobes have no effect.
REQ-013 SHALL advance the modulator exactly once per strobe; accumulators hold otherwise.
REQ-014 SHALL compute y from the modulator (REQ-030/031), N_eff = N_int + y in N_W+2-bit signed arithmetic.
REQ-015 SHALL saturate N_eff to [NMIN, 2^N_W-1], with NMIN = M*(M-1) (12 for M=4).
REQ-016 SHALL register Po = N_eff >> M_LOG2 and So = N_eff[M_LOG2-1:0], so that N_eff = Po*M + So.
REQ-017 SHALL assert upd for exactly one cycle, the cycle after the strobe; Po/So update on the same edge.
REQ-018 SHALL, for back-to-back strobes (LDi high on consecutive cycles), produce one update per strobe with no drop.
REQ-019 SHALL give y = 0 for every strobe while frac = 0 with all accumulators at zero.
REQ-020 SHALL use accumulators of FRAC_W bits that wrap modulo 2^FRAC_W, with carry-out as the stage output.

Reset
REQ-021 SHALL, with rst_n low, asynchronously force Po = NMIN>>M_LOG2 (3), So = NMIN mod M (0), upd = 0.
REQ-022 SHALL clear all accumulators, carry-history registers, and sampled inputs on reset.
REQ-023 SHALL, on reset asserted between strobes, discard any pending update; the first strobe after release behaves as the first strobe after power-up.

Configuration
REQ-030 SHALL, with macro MASH111_EN defined, implement MASH-1-1-1: y = c1 + (c2 - c2[-1]) + (c3 - 2*c3[-1] + c3[-2]), range -3..+4, history indexed per strobe.
REQ-031 SHALL, without MASH111_EN, implement first order: y = c1, range 0..1; stages 2/3 and history are absent.

Structure
REQ-040 SHALL place N_W/FRAC_W/M_LOG2 defaults, NMIN, the y range bounds, and reset values of Po/So in shared package ndiv_pkg.
REQ-041 SHALL implement one accumulator stage as sub-module mash_acc (input word, strobe, sum out, carry out), instantiated three times under MASH111_EN and once without.

Verification
REQ-050 SHALL verify: N_int=50, frac=0, 10 strobes -> every update Po=12, So=2; upd one cycle after each strobe.
REQ-051 SHALL verify, without MASH111_EN: N_int=40, frac=64 -> N_eff repeats 40,40,40,41 (Po/So 10/0 x3, then 10/1).
REQ-052 SHALL verify, with MASH111_EN: N_int=100, frac=128, 256 strobes -> sum of N_eff = 25728 exactly; every y in [-3,+4].
REQ-053 SHALL verify saturation: N_int=12 or 255 with frac=200 under MASH111_EN -> N_eff never below 12 and never above 255.
REQ-054 SHALL verify: rst_n pulsed low mid-sequence -> immediate Po=3, So=0, upd=0; sequence after release matches the from-power-up sequence.
REQ-055 SHALL verify: LDi high 3 consecutive cycles -> 3 consecutive upd pulses; inputs changed with LDi low -> no output change.

Source files
------------

// File: rtl/ndiv_pkg.sv
// Shared constants for the fractional-N divider sequencer.
// Build option: MASH111_EN selects the 3rd-order MASH modulator.
package ndiv_pkg;

  localparam int N_W_DEF    = 8;
  localparam int FRAC_W_DEF = 8;
  localparam int M_LOG2_DEF = 2;

  // Smallest ratio the M/M+1 prescaler can realise contiguously.
  function automatic int nmin(input int m_log2);
    int m;
    m = 1 << m_log2;
    return m * (m - 1);
  endfunction

  localparam int NMIN   = nmin(M_LOG2_DEF);
  localparam int PO_RST = NMIN >> M_LOG2_DEF;
  localparam int SO_RST = NMIN % (1 << M_LOG2_DEF);

`ifdef MASH111_EN
  localparam int Y_MIN = -3;
  localparam int Y_MAX = 4;
`else
  localparam int Y_MIN = 0;
  localparam int Y_MAX = 1;
`endif

endpackage

// File: rtl/mash_acc.sv
// One wrapping accumulator stage; carry-out is the stage output.
// The sum port shows the value the accumulator takes on a strobe.
module mash_acc #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] in_word,
  input  logic         stb,
  output logic [W-1:0] sum,
  output logic         carry
);

  logic [W-1:0] acc;

  assign {carry, sum} = {1'b0, acc} + {1'b0, in_word};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
    end else if (stb) begin
      acc <= sum;
    end
  end

endmodule

// File: rtl/ndiv_seq.sv
// Fractional-N P/S sequencer for a dual-modulus divider.
// Build option: MASH111_EN (MASH-1-1-1 instead of first order).
module ndiv_seq
  import ndiv_pkg::*;
#(
  parameter int N_W    = N_W_DEF,
  parameter int FRAC_W = FRAC_W_DEF,
  parameter int M_LOG2 = M_LOG2_DEF
) (
  input  logic                Fin,
  input  logic                rst_n,
  input  logic [N_W-1:0]      N_int,
  input  logic [FRAC_W-1:0]   frac,
  input  logic                LDi,
  output logic [N_W-M_LOG2-1:0] Po,
  output logic [M_LOG2-1:0]   So,
  output logic                upd
);

  localparam int EW    = N_W + 2;
  localparam int PW    = N_W - M_LOG2;
  localparam int NMIN_L = nmin(M_LOG2);
  localparam int PO_R  = NMIN_L >> M_LOG2;
  localparam int SO_R  = NMIN_L % (1 << M_LOG2);

  localparam logic signed [EW-1:0] NMIN_S = EW'(NMIN_L);
  localparam logic signed [EW-1:0] NMAX_S = EW'((1 << N_W) - 1);

  logic [FRAC_W-1:0]     s1;
  logic                  c1;
  logic signed [EW-1:0]  y;
  logic signed [EW-1:0]  neff_raw;
  logic [N_W-1:0]        neff;
  logic                  unused_sum;

  mash_acc #(.W(FRAC_W)) u_acc1 (
    .clk     (Fin),
    .rst_n   (rst_n),
    .in_word (frac),
    .stb     (LDi),
    .sum     (s1),
    .carry   (c1)
  );

`ifdef MASH111_EN
  logic [FRAC_W-1:0] s2;
  logic [FRAC_W-1:0] s3;
  logic              c2;
  logic              c3;
  logic              c2_d;
  logic              c3_d1;
  logic              c3_d2;

  mash_acc #(.W(FRAC_W)) u_acc2 (
    .clk     (Fin),
    .rst_n   (rst_n),
    .in_word (s1),
    .stb     (LDi),
    .sum     (s2),
    .carry   (c2)
  );

  mash_acc #(.W(FRAC_W)) u_acc3 (
    .clk     (Fin),
    .rst_n   (rst_n),
    .in_word (s2),
    .stb     (LDi),
    .sum     (s3),
    .carry   (c3)
  );

  assign unused_sum = ^s3;

  // Noise-shaping differences use carries from previous strobes.
  assign y = EW'(c1)
           + EW'(c2) - EW'(c2_d)
           + EW'(c3) - (EW'(c3_d1) << 1) + EW'(c3_d2);

  always_ff @(posedge Fin or negedge rst_n) begin
    if (!rst_n) begin
      c2_d  <= 1'b0;
      c3_d1 <= 1'b0;
      c3_d2 <= 1'b0;
    end else if (LDi) begin
      c2_d  <= c2;
      c3_d1 <= c3;
      c3_d2 <= c3_d1;
    end
  end
`else
  assign unused_sum = ^s1;
  assign y = EW'(c1);
`endif

  assign neff_raw = EW'(N_int) + y;

  always_comb begin
    neff = neff_raw[N_W-1:0];
    if (neff_raw < NMIN_S) begin
      neff = N_W'(NMIN_L);
    end else if (neff_raw > NMAX_S) begin
      neff = '1;
    end
  end

  always_ff @(posedge Fin or negedge rst_n) begin
    if (!rst_n) begin
      Po  <= PW'(PO_R);
      So  <= M_LOG2'(SO_R);
      upd <= 1'b0;
    end else begin
      upd <= LDi;
      if (LDi) begin
        Po <= neff[N_W-1:M_LOG2];
        So <= neff[M_LOG2-1:0];
      end
    end
  end

endmodule

// File: tb/tb_ndiv_seq.sv
// Self-checking bench for ndiv_seq against an arithmetic model.
// Honours MASH111_EN the same way the design does.
module tb_ndiv_seq;

  logic       Fin;
  logic       rst_n;
  logic [7:0] N_int;
  logic [7:0] frac;
  logic       LDi;
  logic [5:0] Po;
  logic [1:0] So;
  logic       upd;

  ndiv_seq dut (
    .Fin   (Fin),
    .rst_n (rst_n),
    .N_int (N_int),
    .frac  (frac),
    .LDi   (LDi),
    .Po    (Po),
    .So    (So),
    .upd   (upd)
  );

  initial Fin = 1'b0;
  always #5 Fin = ~Fin;

`ifdef MASH111_EN
  localparam int YLO = -3;
  localparam int YHI = 4;
`else
  localparam int YLO = 0;
  localparam int YHI = 1;
`endif

  int n_chk;
  int n_fail;

  // Reference model state: plain modulo-256 accumulators.
  int a1, a2, a3;
  int h2, h31, h32;
  int exp_po, exp_so;
  int last_neff;

  typedef struct {
    int n;
    int f;
    int exp[8];
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string nm, input int got, input int want);
    n_chk++;
    if (got != want) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, got, want);
    end
  endtask

  task automatic model_reset();
    a1 = 0; a2 = 0; a3 = 0;
    h2 = 0; h31 = 0; h32 = 0;
    exp_po = 3; exp_so = 0;
  endtask

  task automatic model_strobe(input int n, input int f,
                              output int neff);
    int c1, c2, c3, y;
    a1 = a1 + f;  c1 = a1 / 256; a1 = a1 % 256;
    a2 = a2 + a1; c2 = a2 / 256; a2 = a2 % 256;
    a3 = a3 + a2; c3 = a3 / 256; a3 = a3 % 256;
`ifdef MASH111_EN
    y = c1 + (c2 - h2) + (c3 - 2 * h31 + h32);
    h32 = h31; h31 = c3; h2 = c2;
`else
    y = c1;
`endif
    neff = n + y;
    if (neff < 12) neff = 12;
    if (neff > 255) neff = 255;
  endtask

  task automatic tick(input bit ld);
    int ne;
    LDi = ld;
    if (ld) begin
      model_strobe(int'(N_int), int'(frac), ne);
      exp_po = ne / 4;
      exp_so = ne % 4;
      last_neff = ne;
    end
    @(posedge Fin);
    #1;
    chk("upd", int'(upd), int'(ld));
    chk("po", int'(Po), exp_po);
    chk("so", int'(So), exp_so);
    LDi = 1'b0;
  endtask

  // Entered just after a rising edge; reset falls mid-cycle.
  task automatic do_reset();
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_po", int'(Po), 3);
    chk("rst_so", int'(So), 0);
    chk("rst_upd", int'(upd), 0);
    @(posedge Fin);
    #1;
    rst_n = 1'b1;
    model_reset();
  endtask

  function automatic int dut_neff();
    return int'(Po) * 4 + int'(So);
  endfunction

  initial begin
    int sum, y, ne;
    int fr[8];
    int ref_seq[8];
    n_chk = 0;
    n_fail = 0;
    rst_n = 1'b0;
    LDi = 1'b0;
    N_int = 8'd50;
    frac = 8'd0;
    model_reset();
    @(posedge Fin);
    #1;
    do_reset();

    tbl.push_back('{50, 0, '{50, 50, 50, 50, 50, 50, 50, 50}});
    tbl.push_back('{12, 0, '{12, 12, 12, 12, 12, 12, 12, 12}});
    tbl.push_back('{255, 0, '{255, 255, 255, 255,
                              255, 255, 255, 255}});
    tbl.push_back('{5, 0, '{12, 12, 12, 12, 12, 12, 12, 12}});
    tbl.push_back('{0, 0, '{12, 12, 12, 12, 12, 12, 12, 12}});
`ifndef MASH111_EN
    tbl.push_back('{40, 64, '{40, 40, 40, 41, 40, 40, 40, 41}});
    tbl.push_back('{100, 128, '{100, 101, 100, 101,
                                100, 101, 100, 101}});
`endif

    foreach (tbl[v]) begin
      do_reset();
      N_int = 8'(tbl[v].n);
      frac = 8'(tbl[v].f);
      for (int i = 0; i < 8; i++) begin
        tick(1'b1);
        chk($sformatf("tbl%0d_%0d", v, i), dut_neff(), tbl[v].exp[i]);
        tick(1'b0);
      end
    end

    // Back-to-back strobes, then input changes while idle.
    do_reset();
    N_int = 8'd60;
    frac = 8'd77;
    tick(1'b1);
    tick(1'b1);
    tick(1'b1);
    tick(1'b0);
    for (int i = 0; i < 4; i++) begin
      N_int = 8'($urandom_range(0, 255));
      frac = 8'($urandom_range(0, 255));
      tick(1'b0);
    end

    // Long-run average must be exact over the modulus.
    do_reset();
    N_int = 8'd100;
    frac = 8'd128;
    sum = 0;
    for (int i = 0; i < 256; i++) begin
      tick(1'b1);
      sum += dut_neff();
      y = dut_neff() - 100;
      if (y < YLO || y > YHI) begin
        chk("y_range", y, YLO);
      end
    end
    chk("sum_neff", sum, 25728);

    // Saturation at both ends.
    for (int k = 0; k < 2; k++) begin
      do_reset();
      N_int = (k == 0) ? 8'd12 : 8'd255;
      frac = 8'd200;
      for (int i = 0; i < 64; i++) begin
        tick(1'b1);
        ne = dut_neff();
        chk("sat_range", int'(ne >= 12 && ne <= 255), 1);
      end
    end

    // Reset mid-sequence restarts from the power-up state.
    do_reset();
    N_int = 8'd77;
    for (int i = 0; i < 8; i++) begin
      fr[i] = $urandom_range(0, 255);
      frac = 8'(fr[i]);
      tick(1'b1);
      ref_seq[i] = last_neff;
    end
    do_reset();
    for (int i = 0; i < 3; i++) begin
      frac = 8'(fr[i]);
      tick(1'b1);
    end
    do_reset();
    for (int i = 0; i < 8; i++) begin
      frac = 8'(fr[i]);
      tick(1'b1);
      chk($sformatf("replay%0d", i), dut_neff(), ref_seq[i]);
    end

    // Random traffic against the model.
    do_reset();
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        N_int = 8'($urandom_range(0, 255));
        frac = 8'($urandom_range(0, 255));
      end
      tick(1'($urandom_range(0, 1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
